ascon_round_sequencer: RTL and testbench
========================================

Name: ascon_round_sequencer

Overview:
- Iterative Ascon permutation engine that drives the 4-bit round index consumed by the constant-addition stage.
- Accepts a 320-bit state plus a round count (12 for p^a; 8 or 6 for p^b).
- Applies one full round per clock: constant addition, 5-bit S-box layer, linear diffusion.
- Returns the permuted state over a valid/ready handshake.
- Sits between the Ascon mode controller (init/absorb/finalize) and the datapath.

Parameters:
- MAX_ROUNDS, 12, total round-constant schedule length. Index range 0..MAX_ROUNDS-1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  state_in/rounds valid
- in_ready  out  1  block can accept a new permutation request
- rounds  in  4  number of rounds to apply; sampled on accept
- state_in  in  320  x0=[319:256], x1=[255:192], x2=[191:128], x3=[127:64], x4=[63:0]
- out_valid  out  1  state_out holds the finished result
- out_ready  in  1  downstream accepts the result
- state_out  out  320  permuted state, same packing as state_in
- round_number  out  4  current round index; drives the constant-addition stage
- busy  out  1  high in RUN

Behaviour:
- Reset (async, rst=1):
  - FSM=IDLE, state register=0, round_number=0, round counter=0.
  - in_ready=1 once rst deasserts; out_valid=0; busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&in_ready: load state_in, set round_number=MAX_ROUNDS-n, set counter=n.
  - n is the effective count: rounds>12 clamps to 12.
  - n=0: load state unchanged and go directly to DONE (pass-through, out_valid on the next cycle).
  - Otherwise go to RUN.
- RUN, per cycle:
  - in_ready=0, busy=1.
  - Round constant c = {4'hF - round_number, round_number}, equivalent to 0xF0 - 0x0F*round_number.
  - c is XORed into x2[7:0].
  - S-box layer (bitsliced, 64 lanes):
    - x0^=x4; x4^=x3; x2^=x1.
    - t_i=~x_i & x_{i+1 mod 5}; x_i^=t_{i+1 mod 5}.
    - x1^=x0; x0^=x4; x3^=x2; x2=~x2.
  - Linear layer (rotate right):
    - x0^=ror19^ror28
    - x1^=ror61^ror39
    - x2^=ror1^ror6
    - x3^=ror10^ror17
    - x4^=ror7^ror41
  - Register the result; round_number+=1; counter-=1.
  - counter reaches 0 -> DONE.
- Latency: out_valid rises exactly n clock edges after the accepting edge (12 for p^a, 6 for p^b).
- DONE:
  - out_valid=1; state_out holds stable until out_ready.
  - On out_valid&out_ready -> IDLE; out_valid drops on the next edge.
  - in_ready stays 0 during DONE, so there is no overlap with a new request.
- state_out is the state register, valid to sample only while out_valid=1.
- round_number keeps its last value (MAX_ROUNDS) outside RUN. The 4-bit width never wraps because the maximum is 12.
- in_valid during RUN/DONE is ignored; the requester holds the request until in_ready.
- out_ready while not in DONE has no effect.
- rst asserted mid-RUN or mid-DONE aborts immediately: state cleared, out_valid=0, no partial result is emitted.
- rounds and state_in are sampled only at accept; later changes do not affect the operation in flight.

Test Plan:
- rounds=12, in_valid pulse -> round_number sequence 0..11 over 12 cycles, constants F0,E1,D2,...,4B; out_valid on the 12th edge; state_out equals the software Ascon p12 golden model (zero state and random states).
- rounds=6 and rounds=8 -> first round_number 6 (constant 0x96) / 4 (constant 0xB4); latency 6/8 edges; state_out matches the p6/p8 golden model.
- out_ready held 0 for 5 cycles after out_valid -> state_out and out_valid stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
- rounds=0 with state_in=0x0123...(pattern) -> out_valid next edge, state_out equals state_in; rounds=15 -> behaves as 12 (latency 12, p12 result).
- rst asserted at the 5th RUN cycle -> out_valid=0, busy=0, state_out=0 asynchronously; after release a new request completes correctly.
- Back-to-back requests, in_valid held high with out_ready=1 -> second accept occurs the cycle after the result handshake; both results match the model.

Source files
------------

// File: rtl/ascon_round_sequencer.sv
// Iterative Ascon permutation: one full round per clock (constant addition, S-box layer, linear layer),
// with a valid/ready request port, a valid/ready result port and the round index exposed for the datapath.
module ascon_round_sequencer #(
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   rounds,
    input  logic [319:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] state_out,
    output logic [3:0]   round_number,
    output logic         busy
);

    localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [319:0] state_q;
    logic [319:0] round_out;
    logic [3:0]   count_q;
    logic [3:0]   eff_rounds;
    logic         accept;
    logic [7:0]   rc;
    logic [63:0]  x0, x1, x2, x3, x4;
    logic [63:0]  t0, t1, t2, t3, t4;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Requests longer than the constant schedule run the full schedule.
    assign eff_rounds = (rounds > MAX_R) ? MAX_R : rounds;
    assign accept     = in_valid && (fsm_q == IDLE);
    assign state_out  = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm_q <= IDLE;
        else     fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d     = fsm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_d = (eff_rounds == 4'd0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (count_q == 4'd1) fsm_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Starting the index at MAX_ROUNDS-n makes short permutations use the tail of the constant schedule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= '0;
            round_number <= '0;
            count_q      <= '0;
        end else if (accept) begin
            state_q      <= state_in;
            round_number <= MAX_R - eff_rounds;
            count_q      <= eff_rounds;
        end else if (fsm_q == RUN) begin
            state_q      <= round_out;
            round_number <= round_number + 4'd1;
            count_q      <= count_q - 4'd1;
        end
    end

    always_comb begin
        rc = {4'hF - round_number, round_number};
        x0 = state_q[319:256];
        x1 = state_q[255:192];
        x2 = state_q[191:128] ^ {56'd0, rc};
        x3 = state_q[127:64];
        x4 = state_q[63:0];

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        round_out = {x0 ^ ror(x0, 19) ^ ror(x0, 28),
                     x1 ^ ror(x1, 61) ^ ror(x1, 39),
                     x2 ^ ror(x2, 1)  ^ ror(x2, 6),
                     x3 ^ ror(x3, 10) ^ ror(x3, 17),
                     x4 ^ ror(x4, 7)  ^ ror(x4, 41)};
    end

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Directed bench for ascon_round_sequencer; expected states come from a table-driven
// per-column S-box model of the Ascon round.
module tb_ascon_round_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   rounds;
    logic [319:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [319:0] state_out;
    logic [3:0]   round_number;
    logic         busy;

    int passCount  = 0;
    int checkCount = 0;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    ascon_round_sequencer #(.MAX_ROUNDS(12)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rounds(rounds), .state_in(state_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .state_out(state_out), .round_number(round_number), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [319:0] observed, input logic [319:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        logic [63:0] r;
        for (int k = 0; k < 64; k++) r[k] = v[(k + n) % 64];
        return r;
    endfunction

    function automatic logic [319:0] roundModel(input logic [319:0] s, input int r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  idx, o;
        logic [7:0]  c;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        c = 8'(240 - 15*r);
        x[2][7:0] = x[2][7:0] ^ c;
        for (int b = 0; b < 64; b++) begin
            idx = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            o = SBOX[idx];
            for (int i = 0; i < 5; i++) y[i][b] = o[4-i];
        end
        for (int i = 0; i < 5; i++) x[i] = y[i] ^ rotr(y[i], ROT_A[i]) ^ rotr(y[i], ROT_B[i]);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] permModel(input logic [319:0] s, input int n);
        logic [319:0] v = s;
        for (int r = 12 - n; r < 12; r++) v = roundModel(v, r);
        return v;
    endfunction

    function automatic logic [319:0] randomState();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Accepts one request, tracks the round index each cycle, checks latency and result, then drains it.
    task automatic applyStimulus(input string tag, input logic [319:0] s, input logic [3:0] r,
                                 input int n, input int hold);
        logic [319:0] expState;
        int edges;
        expState = permModel(s, n);
        @(negedge clk);
        checkOutput({tag, ".in_ready"}, 320'(in_ready), 320'(1));
        in_valid = 1'b1;
        rounds   = r;
        state_in = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rounds   = 4'd3;
        state_in = randomState();
        edges = 0;
        while (!out_valid && edges < 40) begin
            checkOutput({tag, ".round_number"}, 320'(round_number), 320'(12 - n + edges));
            @(posedge clk); #1;
            edges++;
        end
        checkOutput({tag, ".latency"}, 320'(edges), 320'(n));
        checkOutput({tag, ".state_out"}, state_out, expState);
        checkOutput({tag, ".idle_flags"}, 320'({busy, in_ready, round_number}), 320'({1'b0, 1'b0, 4'd12}));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput({tag, ".hold"}, 320'({out_valid, in_ready}), 320'(2'b10));
            checkOutput({tag, ".hold_state"}, state_out, expState);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, ".released"}, 320'({out_valid, in_ready}), 320'(2'b01));
    endtask

    task automatic waitResult(input string tag, input logic [319:0] expState);
        int edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput({tag, ".state_out"}, state_out, expState);
    endtask

    initial begin
        logic [319:0] sA, sB;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rounds = '0; state_in = '0;
        #12;
        checkOutput("reset.outs", 320'({out_valid, busy, round_number}), 320'(0));
        checkOutput("reset.state", state_out, 320'(0));
        @(negedge clk); rst = 1'b0;
        #1 checkOutput("reset.in_ready", 320'(in_ready), 320'(1));

        applyStimulus("p12_zero", 320'(0), 4'd12, 12, 0);
        applyStimulus("p12_rand", randomState(), 4'd12, 12, 0);
        applyStimulus("p6_rand", randomState(), 4'd6, 6, 0);
        applyStimulus("p8_hold", randomState(), 4'd8, 8, 5);
        applyStimulus("p0_pass", {5{64'h0123456789abcdef}}, 4'd0, 0, 0);
        applyStimulus("p15_clamp", randomState(), 4'd15, 12, 0);

        // Abort in the fifth RUN cycle, then prove the engine recovers.
        @(negedge clk);
        in_valid = 1'b1; rounds = 4'd12; state_in = randomState();
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort.flags", 320'({out_valid, busy}), 320'(0));
        checkOutput("abort.state", state_out, 320'(0));
        @(negedge clk); rst = 1'b0;
        applyStimulus("after_abort", randomState(), 4'd12, 12, 0);

        // Back-to-back: request held valid, downstream always ready.
        sA = randomState();
        sB = randomState();
        @(negedge clk);
        in_valid = 1'b1; rounds = 4'd6; state_in = sA; out_ready = 1'b1;
        @(posedge clk); #1;
        rounds = 4'd8; state_in = sB;
        waitResult("b2b_first", permModel(sA, 6));
        @(posedge clk); #1;
        checkOutput("b2b.handshake", 320'({out_valid, in_ready}), 320'(2'b01));
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("b2b.second_accept", 320'({busy, round_number}), 320'({1'b1, 4'd4}));
        waitResult("b2b_second", permModel(sB, 8));
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("b2b.final_idle", 320'({out_valid, in_ready}), 320'(2'b01));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
